// File: rtl/apb_arb_pkg.sv
// Shared types and default sizes for the APB event arbiter.
// Imported by the arbiter top and its round-robin picker.
package apb_arb_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Searches pending starting at ptr and returns the first hit.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N  = DEF_N_REQ,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && pending[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_event_arbiter.sv
// Converts request rising edges into round-robin APB transfers.
// One SETUP/ACCESS per grant, then a one-cycle done pulse.
module apb_event_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        req_write_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
  output logic [N_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_W-1:0]       paddr_o,
  output logic [DATA_W-1:0]       pwdata_o,
  input  logic [DATA_W-1:0]       prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int IW = $clog2(N_REQ);

  apb_state_e state, state_n;

  logic [N_REQ-1:0]  req_ff, pending, rise;
  logic [N_REQ-1:0]  clr, grant, hold_oh;
  logic [IW-1:0]     ptr, g_idx;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic              hold_write;
  logic              launch, complete;

  assign rise     = req_i & ~req_ff;
  assign launch   = (state == IDLE) && (|pending);
  assign complete = (state == ACCESS) && pready_i;
  assign clr      = complete ? hold_oh : '0;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .pending (pending),
    .ptr     (ptr),
    .grant   (grant),
    .idx     (g_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|pending) state_n = SETUP;
      SETUP:   state_n = ACCESS;
      ACCESS:  if (pready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A rise landing on the completion cycle survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ff  <= '0;
      pending <= '0;
    end else begin
      req_ff  <= req_i;
      pending <= (pending & ~clr) | rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_oh    <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_write <= 1'b0;
      ptr        <= '0;
    end else if (launch) begin
      hold_oh    <= grant;
      hold_addr  <= req_addr_i[g_idx*ADDR_W +: ADDR_W];
      hold_wdata <= req_wdata_i[g_idx*DATA_W +: DATA_W];
      hold_write <= req_write_i[g_idx];
      ptr        <= (g_idx == IW'(N_REQ-1)) ? '0 : g_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_o  <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      done_o <= clr;
      if (complete) begin
        rdata_o <= prdata_i;
        err_o   <= pslverr_i;
      end
    end
  end

  assign busy_o    = (state != IDLE);
  assign psel_o    = (state != IDLE);
  assign penable_o = (state == ACCESS);
  assign pwrite_o  = hold_write;
  assign paddr_o   = hold_addr;
  assign pwdata_o  = hold_write ? hold_wdata : '0;

endmodule
